// File: rtl/buzzer_pkg.sv
// Shared types and default timing for the buzzer sequencer/arbiter.
// States, active_src encodings and the 50 MHz timing defaults live here.
package buzzer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HPS     = 2'd1,
      EVT_ON  = 2'd2,
      EVT_OFF = 2'd3
   } state_t;

   localparam logic [1:0] SRC_NONE = 2'b00;
   localparam logic [1:0] SRC_HPS  = 2'b01;
   localparam logic [1:0] SRC_EVT  = 2'b10;

   localparam int         DEF_TONE_DIV     = 12500;
   localparam int         DEF_BEEP_ON_CYC  = 5000000;
   localparam int         DEF_BEEP_OFF_CYC = 5000000;
   localparam logic [7:0] DEF_EVT_AMOUNT   = 8'd200;

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/buzzer_tone_gen.sv
// Square-wave tone generator gated by an 8-bit volume PWM carrier.
// The pin is registered, so it lags run/amount by one clock.
module buzzer_tone_gen
   import buzzer_pkg::*;
#(
   parameter int TONE_DIV = DEF_TONE_DIV
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       run,
   input  logic       start,
   input  logic [7:0] amount,
   output logic       pwm_out
);

   localparam int            TW        = cnt_width(TONE_DIV);
   localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

   logic [TW-1:0] tone_cnt;
   logic          tone_ph;
   logic [7:0]    vol_cnt;

   // start restarts the tone with a high half-period at every entry into a sounding state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tone_cnt <= '0;
         tone_ph  <= 1'b0;
      end else if (start) begin
         tone_cnt <= '0;
         tone_ph  <= 1'b1;
      end else if (run) begin
         if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            tone_ph  <= ~tone_ph;
         end else begin
            tone_cnt <= tone_cnt + TW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vol_cnt <= 8'd0;
      end else begin
         vol_cnt <= vol_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_out <= 1'b0;
      end else begin
         pwm_out <= run & tone_ph & (vol_cnt < amount);
      end
   end

endmodule

// File: rtl/buzzer_seq_arb.sv
// Shares the buzzer between the HPS level request and fabric event beep requests.
// Events preempt HPS; one pending event may queue behind a running sequence.
module buzzer_seq_arb
   import buzzer_pkg::*;
#(
   parameter int         TONE_DIV     = DEF_TONE_DIV,
   parameter int         BEEP_ON_CYC  = DEF_BEEP_ON_CYC,
   parameter int         BEEP_OFF_CYC = DEF_BEEP_OFF_CYC,
   parameter logic [7:0] EVT_AMOUNT   = DEF_EVT_AMOUNT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       hps_en,
   input  logic [7:0] hps_amount,
   input  logic       evt_req,
   input  logic [2:0] evt_beeps,
   output logic       evt_ack,
   output logic       evt_drop,
   output logic       busy,
   output logic [1:0] active_src,
   output logic       pwm_out
);

   localparam int DUR_MAX = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
   localparam int DW      = cnt_width(DUR_MAX);
   localparam logic [DW-1:0] ON_LAST  = DW'(BEEP_ON_CYC - 1);
   localparam logic [DW-1:0] OFF_LAST = DW'(BEEP_OFF_CYC - 1);

   state_t        state;
   state_t        next_state;
   logic          consume;
   logic          slot_full;
   logic [2:0]    slot_cnt;
   logic [2:0]    beeps_left;
   logic [DW-1:0] dur_cnt;
   logic          on_done;
   logic          off_done;
   logic          take;
   logic          sounding;
   logic          tone_start;
   logic [7:0]    cur_amount;

   assign on_done  = (dur_cnt == ON_LAST);
   assign off_done = (dur_cnt == OFF_LAST);

   // A slot freed by this cycle's consume can take a new request in the same cycle.
   assign take = evt_req && (evt_beeps != 3'd0) && (!slot_full || consume);

   assign tone_start = (next_state != state) && ((next_state == EVT_ON) || (next_state == HPS));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      consume    = 1'b0;
      case (state)
         IDLE: begin
            if (slot_full) begin
               next_state = EVT_ON;
               consume    = 1'b1;
            end else if (hps_en) begin
               next_state = HPS;
            end
         end
         HPS: begin
            if (slot_full) begin
               next_state = EVT_ON;
               consume    = 1'b1;
            end else if (!hps_en) begin
               next_state = IDLE;
            end
         end
         EVT_ON: begin
            if (on_done) begin
               next_state = EVT_OFF;
            end
         end
         EVT_OFF: begin
            if (off_done) begin
               if (beeps_left == 3'd1) begin
                  if (slot_full) begin
                     next_state = EVT_ON;
                     consume    = 1'b1;
                  end else begin
                     next_state = IDLE;
                  end
               end else begin
                  next_state = EVT_ON;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      active_src = SRC_NONE;
      sounding   = 1'b0;
      cur_amount = EVT_AMOUNT;
      case (state)
         HPS: begin
            active_src = SRC_HPS;
            sounding   = 1'b1;
            cur_amount = hps_amount;
         end
         EVT_ON: begin
            busy       = 1'b1;
            active_src = SRC_EVT;
            sounding   = 1'b1;
         end
         EVT_OFF: begin
            busy       = 1'b1;
            active_src = SRC_EVT;
         end
         default: ;
      endcase
   end

   // Beep timing: the duration counter restarts on every state change.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dur_cnt    <= '0;
         beeps_left <= 3'd0;
      end else begin
         if (next_state != state) begin
            dur_cnt <= '0;
         end else if ((state == EVT_ON) || (state == EVT_OFF)) begin
            dur_cnt <= dur_cnt + DW'(1);
         end
         if (consume) begin
            beeps_left <= slot_cnt;
         end else if ((state == EVT_OFF) && off_done) begin
            beeps_left <= beeps_left - 3'd1;
         end
      end
   end

   // Zero-beep requests are acknowledged but never occupy the slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_full <= 1'b0;
         slot_cnt  <= 3'd0;
         evt_ack   <= 1'b0;
         evt_drop  <= 1'b0;
      end else begin
         evt_ack <= evt_req && ((evt_beeps == 3'd0) || !slot_full || consume);
         if (take) begin
            slot_full <= 1'b1;
            slot_cnt  <= evt_beeps;
         end else if (consume) begin
            slot_full <= 1'b0;
         end
         if (evt_req && (evt_beeps != 3'd0) && slot_full && !consume) begin
            evt_drop <= 1'b1;
         end
      end
   end

   buzzer_tone_gen #(
      .TONE_DIV (TONE_DIV)
   ) u_tone (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (sounding),
      .start   (tone_start),
      .amount  (cur_amount),
      .pwm_out (pwm_out)
   );

endmodule

// File: tb/tb_buzzer_seq_arb.sv
// Scoreboard bench for buzzer_seq_arb: stimulus queues expected values per cycle,
// a negedge monitor compares them and matches evt_ack pulses against expected cycles.
module tb_buzzer_seq_arb;

   localparam int         TONE_DIV = 4;
   localparam int         ON_CYC   = 16;
   localparam int         OFF_CYC  = 8;
   localparam logic [7:0] EVT_AMT  = 8'd255;

   localparam int SIG_PWM  = 0;
   localparam int SIG_BUSY = 1;
   localparam int SIG_SRC  = 2;
   localparam int SIG_DROP = 3;
   localparam int SIG_ACK  = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       hps_en = 1'b0;
   logic [7:0] hps_amount = 8'd0;
   logic       evt_req = 1'b0;
   logic [2:0] evt_beeps = 3'd0;
   logic       evt_ack;
   logic       evt_drop;
   logic       busy;
   logic [1:0] active_src;
   logic       pwm_out;

   buzzer_seq_arb #(
      .TONE_DIV     (TONE_DIV),
      .BEEP_ON_CYC  (ON_CYC),
      .BEEP_OFF_CYC (OFF_CYC),
      .EVT_AMOUNT   (EVT_AMT)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .hps_en     (hps_en),
      .hps_amount (hps_amount),
      .evt_req    (evt_req),
      .evt_beeps  (evt_beeps),
      .evt_ack    (evt_ack),
      .evt_drop   (evt_drop),
      .busy       (busy),
      .active_src (active_src),
      .pwm_out    (pwm_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int sig;
      int val;
   } exp_t;

   exp_t exp_q[$];
   int   ack_q[$];
   int   checks = 0;
   int   passes = 0;
   int   rst_cyc = 0;
   int   mon_got;

   function automatic string sig_name(input int s);
      case (s)
         SIG_PWM:  return "pwm_out";
         SIG_BUSY: return "busy";
         SIG_SRC:  return "active_src";
         SIG_DROP: return "evt_drop";
         default:  return "evt_ack";
      endcase
   endfunction

   function automatic int sig_val(input int s);
      case (s)
         SIG_PWM:  return int'(pwm_out);
         SIG_BUSY: return int'(busy);
         SIG_SRC:  return int'(active_src);
         SIG_DROP: return int'(evt_drop);
         default:  return int'(evt_ack);
      endcase
   endfunction

   task automatic check_output(input string name, input int c, input int got, input int want);
      checks++;
      if (got == want) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, c, got, want);
      end
   endtask

   task automatic expect_at(input int c, input int s, input int v);
      exp_t e;
      e.cyc = c;
      e.sig = s;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int vol_at(input int n);
      return (n - rst_cyc) & 255;
   endfunction

   // Pin value in cycle m for a beep burst whose EVT_ON starts in cycle b.
   function automatic int burst_pwm(input int m, input int b);
      int  n;
      bit  on;
      bit  ph;
      n  = m - 1;
      on = (n >= b) && (n <= b + ON_CYC - 1);
      ph = (((n - b) / TONE_DIV) % 2) == 0;
      return int'(on && ph && (vol_at(n) < int'(EVT_AMT)));
   endfunction

   task automatic expect_burst(input int b);
      for (int m = b; m < b + ON_CYC + OFF_CYC; m++) begin
         expect_at(m, SIG_BUSY, 1);
         expect_at(m, SIG_SRC, 2);
      end
      for (int m = b + 1; m <= b + ON_CYC + OFF_CYC; m++) begin
         expect_at(m, SIG_PWM, burst_pwm(m, b));
      end
   endtask

   task automatic apply_stimulus_evt(input int beeps, input bit want_ack);
      if (want_ack) ack_q.push_back(cyc + 1);
      evt_req   = 1'b1;
      evt_beeps = 3'(beeps);
      wait_cycles(1);
      evt_req   = 1'b0;
      evt_beeps = 3'd0;
   endtask

   always @(negedge clk) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].cyc == cyc) begin
            mon_got = sig_val(exp_q[i].sig);
            check_output(sig_name(exp_q[i].sig), cyc, mon_got, exp_q[i].val);
            exp_q.delete(i);
         end else if (exp_q[i].cyc < cyc) begin
            check_output({sig_name(exp_q[i].sig), " missed"}, exp_q[i].cyc, -1, exp_q[i].val);
            exp_q.delete(i);
         end
      end
      if (evt_ack) begin
         if (ack_q.size() == 0) begin
            check_output("evt_ack unexpected", cyc, 1, 0);
         end else begin
            check_output("evt_ack cycle", cyc, cyc, ack_q.pop_front());
         end
      end else if (ack_q.size() > 0 && ack_q[0] < cyc) begin
         check_output("evt_ack missing", cyc, 0, ack_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int s;
      int t;
      int u;
      int a;
      int n;
      int k;

      // Reset state.
      for (int c = 1; c <= 2; c++) begin
         for (int sg = 0; sg <= 4; sg++) expect_at(c, sg, 0);
      end
      wait_cycles(3);
      reset_n = 1'b1;
      rst_cyc = cyc;
      wait_cycles(2);

      // Test 1: HPS at amount 0 stays silent, then full volume with an 8-cycle tone.
      $display("[TB] test 1: HPS sound");
      s = cyc;
      hps_en = 1'b1;
      hps_amount = 8'd0;
      expect_at(s + 2, SIG_SRC, 1);
      expect_at(s + 2, SIG_BUSY, 0);
      for (int m = s + 1; m <= s + 600; m++) expect_at(m, SIG_PWM, 0);
      wait_cycles(600);
      t = cyc;
      hps_amount = 8'd255;
      for (int m = t + 1; m <= t + 300; m++) begin
         n = m - 1;
         k = n - (s + 1);
         expect_at(m, SIG_PWM, int'((((k / TONE_DIV) % 2) == 0) && (vol_at(n) != 255)));
      end
      wait_cycles(300);
      u = cyc;
      hps_en = 1'b0;
      hps_amount = 8'd0;
      expect_at(u + 2, SIG_SRC, 0);
      expect_at(u + 2, SIG_PWM, 0);
      wait_cycles(4);

      // Test 2: three beeps from IDLE.
      $display("[TB] test 2: three-beep event");
      a = cyc;
      expect_burst(a + 2);
      expect_burst(a + 26);
      expect_burst(a + 50);
      expect_at(a + 74, SIG_BUSY, 0);
      expect_at(a + 74, SIG_SRC, 0);
      expect_at(a + 75, SIG_PWM, 0);
      apply_stimulus_evt(3, 1'b1);
      wait_cycles(79);

      // Test 3: event preempts HPS mid tone period, HPS resumes via one IDLE cycle.
      $display("[TB] test 3: event preempts HPS");
      a = cyc;
      hps_en = 1'b1;
      hps_amount = 8'd100;
      expect_at(a + 2, SIG_SRC, 1);
      expect_at(a + 6, SIG_SRC, 1);
      expect_burst(a + 7);
      expect_at(a + 31, SIG_SRC, 0);
      expect_at(a + 31, SIG_BUSY, 0);
      expect_at(a + 32, SIG_SRC, 1);
      wait_cycles(5);
      apply_stimulus_evt(1, 1'b1);
      wait_cycles(34);
      u = cyc;
      hps_en = 1'b0;
      hps_amount = 8'd0;
      expect_at(u + 2, SIG_SRC, 0);
      wait_cycles(4);

      // Test 4: one request chains, a second one is dropped.
      $display("[TB] test 4: chaining and drop");
      a = cyc;
      expect_burst(a + 2);
      expect_burst(a + 26);
      expect_burst(a + 50);
      expect_at(a + 8, SIG_DROP, 0);
      expect_at(a + 9, SIG_DROP, 1);
      expect_at(a + 60, SIG_DROP, 1);
      expect_at(a + 74, SIG_BUSY, 0);
      expect_at(a + 74, SIG_SRC, 0);
      apply_stimulus_evt(1, 1'b1);
      wait_cycles(4);
      apply_stimulus_evt(2, 1'b1);
      wait_cycles(2);
      apply_stimulus_evt(3, 1'b0);
      wait_cycles(71);

      // Test 5: zero-beep request is acked and ignored.
      $display("[TB] test 5: zero-beep request");
      a = cyc;
      expect_at(a + 1, SIG_ACK, 1);
      expect_at(a + 2, SIG_ACK, 0);
      expect_at(a + 2, SIG_SRC, 0);
      expect_at(a + 3, SIG_SRC, 0);
      expect_at(a + 2, SIG_BUSY, 0);
      expect_at(a + 4, SIG_DROP, 1);
      for (int m = a + 2; m <= a + 5; m++) expect_at(m, SIG_PWM, 0);
      apply_stimulus_evt(0, 1'b1);
      wait_cycles(7);

      // Test 6: asynchronous reset in EVT_ON with a full slot.
      $display("[TB] test 6: reset mid-sequence");
      a = cyc;
      expect_at(a + 5, SIG_BUSY, 1);
      expect_at(a + 5, SIG_SRC, 2);
      for (int sg = 0; sg <= 4; sg++) expect_at(a + 6, sg, 0);
      for (int m = a + 9; m <= a + 70; m++) begin
         expect_at(m, SIG_BUSY, 0);
         expect_at(m, SIG_SRC, 0);
         expect_at(m, SIG_PWM, 0);
      end
      expect_at(a + 20, SIG_DROP, 0);
      apply_stimulus_evt(2, 1'b1);
      wait_cycles(3);
      apply_stimulus_evt(1, 1'b1);
      @(posedge clk);
      #1 reset_n = 1'b0;
      wait_cycles(3);
      reset_n = 1'b1;
      rst_cyc = cyc;
      wait_cycles(66);

      foreach (exp_q[i]) begin
         check_output({sig_name(exp_q[i].sig), " never checked"}, exp_q[i].cyc, -1, exp_q[i].val);
      end
      foreach (ack_q[i]) begin
         check_output("evt_ack never seen", ack_q[i], -1, ack_q[i]);
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
